spm_bank_arbiter: RTL and testbench

SPM_BANK_ARBITER -- requirements
Module: spm_bank_arbiter

---
 rtl/spm_bank_arbiter.sv | 159 +++++++++++++++
 tb/tb_spm_bank_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spm_bank_arbiter.sv
// spm_bank_arbiter: multi-port to multi-bank scratchpad crossbar.
// Each bank runs its own round-robin arbiter over the requester ports; the
// winner's request is forwarded to the bank in the grant cycle and the bank's
// read data is routed back to that port one cycle later.
module spm_bank_arbiter #(
    parameter  int unsigned NumPorts      = 2,
    parameter  int unsigned NumBanks      = 4,
    parameter  int unsigned AddrWidth     = 18,
    parameter  int unsigned DataWidth     = 64,
    parameter  int unsigned BankWords     = 1024,
    localparam int unsigned BankAddrWidth = $clog2(BankWords),
    localparam int unsigned StrbWidth     = DataWidth / 8
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NumPorts-1:0]                     req_i,
    output logic [NumPorts-1:0]                     gnt_o,
    input  logic [NumPorts-1:0][AddrWidth-1:0]      addr_i,
    input  logic [NumPorts-1:0]                     we_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]      wdata_i,
    input  logic [NumPorts-1:0][StrbWidth-1:0]      strb_i,
    output logic [NumPorts-1:0]                     rvalid_o,
    output logic [NumPorts-1:0][DataWidth-1:0]      rdata_o,
    output logic [NumBanks-1:0]                     bank_req_o,
    output logic [NumBanks-1:0]                     bank_we_o,
    output logic [NumBanks-1:0][BankAddrWidth-1:0]  bank_addr_o,
    output logic [NumBanks-1:0][DataWidth-1:0]      bank_wdata_o,
    output logic [NumBanks-1:0][StrbWidth-1:0]      bank_be_o,
    input  logic [NumBanks-1:0][DataWidth-1:0]      bank_rdata_i
);

    localparam int unsigned ByteOff  = $clog2(StrbWidth);
    localparam int unsigned SelW     = (NumBanks > 1) ? $clog2(NumBanks) : 0;
    localparam int unsigned SelWidth = (SelW > 0) ? SelW : 1;
    localparam int unsigned PtrWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    localparam logic [PtrWidth:0]   PortCount = (PtrWidth + 1)'(NumPorts);
    localparam logic [PtrWidth-1:0] LastPort  = PtrWidth'(NumPorts - 1);

    logic [SelWidth-1:0]      port_bank   [NumPorts];
    logic [BankAddrWidth-1:0] port_word   [NumPorts];
    logic [PtrWidth-1:0]      rr_q        [NumBanks];
    logic [PtrWidth-1:0]      rr_next     [NumBanks];
    logic [PtrWidth-1:0]      win_port    [NumBanks];
    logic [NumBanks-1:0]      win_valid;
    logic [NumPorts-1:0]      gnt;
    logic [NumPorts-1:0]      resp_valid_q;
    logic [NumPorts-1:0]      resp_read_q;
    logic [SelWidth-1:0]      resp_bank_q [NumPorts];

    // Address decode: word-interleaved bank select above the byte offset,
    // bank word index above that; upper address bits fall off the casts.
    always_comb begin
        for (int unsigned p = 0; p < NumPorts; p++) begin
            port_bank[p] = (SelW > 0) ? SelWidth'(addr_i[p] >> ByteOff) : '0;
            port_word[p] = BankAddrWidth'(addr_i[p] >> (ByteOff + SelW));
        end
    end

    // Per-bank round-robin: scan ports starting at rr_q[b], first hit wins.
    always_comb begin
        logic [PtrWidth:0]   cand_sum;
        logic [PtrWidth-1:0] cand;
        cand_sum  = '0;
        cand      = '0;
        win_valid = '0;
        gnt       = '0;
        for (int unsigned b = 0; b < NumBanks; b++) begin
            win_port[b] = '0;
            rr_next[b]  = rr_q[b];
            for (int unsigned i = 0; i < NumPorts; i++) begin
                cand_sum = {1'b0, rr_q[b]} + (PtrWidth + 1)'(i);
                if (cand_sum >= PortCount) begin
                    cand_sum = cand_sum - PortCount;
                end
                cand = cand_sum[PtrWidth-1:0];
                if (!win_valid[b] && req_i[cand] && (port_bank[cand] == SelWidth'(b))) begin
                    win_valid[b] = 1'b1;
                    win_port[b]  = cand;
                end
            end
            if (win_valid[b]) begin
                gnt[win_port[b]] = 1'b1;
                rr_next[b]       = (win_port[b] == LastPort) ? '0 : win_port[b] + 1'b1;
            end
        end
        // Reset suppresses every grant so nothing is accepted while rst_i is high.
        if (rst_i) begin
            win_valid = '0;
            gnt       = '0;
        end
    end

    assign gnt_o = gnt;

    // Forward the winning port's payload to each bank; idle banks drive zero.
    always_comb begin
        bank_req_o   = '0;
        bank_we_o    = '0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        bank_be_o    = '0;
        for (int unsigned b = 0; b < NumBanks; b++) begin
            if (win_valid[b]) begin
                bank_req_o[b]   = 1'b1;
                bank_we_o[b]    = we_i[win_port[b]];
                bank_addr_o[b]  = port_word[win_port[b]];
                bank_wdata_o[b] = wdata_i[win_port[b]];
                bank_be_o[b]    = strb_i[win_port[b]];
            end
        end
    end

    // Round-robin pointers advance past the winner only on granting cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned b = 0; b < NumBanks; b++) begin
                rr_q[b] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < NumBanks; b++) begin
                if (win_valid[b]) begin
                    rr_q[b] <= rr_next[b];
                end
            end
        end
    end

    // Response routing: remember which bank each accepted request went to.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_valid_q <= '0;
            resp_read_q  <= '0;
            for (int unsigned p = 0; p < NumPorts; p++) begin
                resp_bank_q[p] <= '0;
            end
        end else begin
            resp_valid_q <= gnt;
            for (int unsigned p = 0; p < NumPorts; p++) begin
                if (gnt[p]) begin
                    resp_read_q[p] <= !we_i[p];
                    resp_bank_q[p] <= port_bank[p];
                end
            end
        end
    end

    // Responses come only from the routing registers; writes return zero data.
    always_comb begin
        rvalid_o = resp_valid_q;
        rdata_o  = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            if (resp_valid_q[p] && resp_read_q[p]) begin
                rdata_o[p] = bank_rdata_i[resp_bank_q[p]];
            end
        end
    end

endmodule

// File: tb/tb_spm_bank_arbiter.sv
// Directed bench for spm_bank_arbiter: a default 2-port instance and a
// 4-port instance; expected responses are queued at grant time and popped
// when rvalid appears one cycle later.
module tb_spm_bank_arbiter;

    logic clk = 1'b0;
    logic rst;

    // 2-port / 4-bank instance
    logic [1:0]        req, we, gnt, rvalid;
    logic [1:0][17:0]  addr;
    logic [1:0][63:0]  wdata, rdata;
    logic [1:0][7:0]   strb;
    logic [3:0]        breq, bwe;
    logic [3:0][9:0]   baddr;
    logic [3:0][63:0]  bwdata, brdata;
    logic [3:0][7:0]   bbe;

    // 4-port / 4-bank instance
    logic [3:0]        req4, we4, gnt4, rvalid4;
    logic [3:0][17:0]  addr4;
    logic [3:0][63:0]  wdata4, rdata4;
    logic [3:0][7:0]   strb4;
    logic [3:0]        breq4, bwe4;
    logic [3:0][9:0]   baddr4;
    logic [3:0][63:0]  bwdata4, brdata4;
    logic [3:0][7:0]   bbe4;

    typedef struct {
        logic [1:0]  port;
        logic [63:0] data;
    } resp_t;

    resp_t sbq[$];
    resp_t sbq4[$];

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] Garbage = 64'hFEED_FACE_0BAD_F00D;

    spm_bank_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
        .wdata_i(wdata), .strb_i(strb),
        .rvalid_o(rvalid), .rdata_o(rdata),
        .bank_req_o(breq), .bank_we_o(bwe), .bank_addr_o(baddr),
        .bank_wdata_o(bwdata), .bank_be_o(bbe), .bank_rdata_i(brdata)
    );

    spm_bank_arbiter #(.NumPorts(4)) dut4 (
        .clk_i(clk), .rst_i(rst),
        .req_i(req4), .gnt_o(gnt4), .addr_i(addr4), .we_i(we4),
        .wdata_i(wdata4), .strb_i(strb4),
        .rvalid_o(rvalid4), .rdata_o(rdata4),
        .bank_req_o(breq4), .bank_we_o(bwe4), .bank_addr_o(baddr4),
        .bank_wdata_o(bwdata4), .bank_be_o(bbe4), .bank_rdata_i(brdata4)
    );

    always #5 clk = ~clk;

    // Contents the bank model returns for a read of word w in bank b.
    function automatic logic [63:0] mem_word(input int unsigned b, input logic [9:0] w);
        return {16'hA5A5, 8'(b), 8'h3C, 22'h0, w};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle on the 2-port instance; called just after a negedge with inputs set.
    task automatic step(input logic [1:0] exp_gnt, input logic [3:0] exp_breq, input string tag);
        logic [3:0]      req_snap;
        logic [3:0]      we_snap;
        logic [3:0][9:0] addr_snap;
        logic [1:0]      exp_rv;
        resp_t           r;
        #1;
        check({tag, " gnt"}, 64'(gnt), 64'(exp_gnt));
        check({tag, " bank_req"}, 64'(breq), 64'(exp_breq));
        for (int p = 0; p < 2; p++) begin
            if (exp_gnt[p]) begin
                r.port = 2'(p);
                r.data = we[p] ? 64'h0 : mem_word(addr[p][4:3], addr[p][14:5]);
                sbq.push_back(r);
            end
        end
        req_snap  = breq;
        we_snap   = bwe;
        addr_snap = baddr;
        @(posedge clk);
        for (int b = 0; b < 4; b++) begin
            brdata[b] = (req_snap[b] && !we_snap[b]) ? mem_word(b, addr_snap[b]) : Garbage;
        end
        #1;
        exp_rv = '0;
        while (sbq.size() > 0) begin
            r = sbq.pop_front();
            exp_rv[r.port[0]] = 1'b1;
            check({tag, " rdata"}, rdata[r.port[0]], r.data);
        end
        check({tag, " rvalid"}, 64'(rvalid), 64'(exp_rv));
        @(negedge clk);
    endtask

    // Same as step, for the 4-port instance.
    task automatic step4(input logic [3:0] exp_gnt, input logic [3:0] exp_breq, input string tag);
        logic [3:0]      req_snap;
        logic [3:0]      we_snap;
        logic [3:0][9:0] addr_snap;
        logic [3:0]      exp_rv;
        resp_t           r;
        #1;
        check({tag, " gnt4"}, 64'(gnt4), 64'(exp_gnt));
        check({tag, " bank_req4"}, 64'(breq4), 64'(exp_breq));
        for (int p = 0; p < 4; p++) begin
            if (exp_gnt[p]) begin
                r.port = 2'(p);
                r.data = we4[p] ? 64'h0 : mem_word(addr4[p][4:3], addr4[p][14:5]);
                sbq4.push_back(r);
            end
        end
        req_snap  = breq4;
        we_snap   = bwe4;
        addr_snap = baddr4;
        @(posedge clk);
        for (int b = 0; b < 4; b++) begin
            brdata4[b] = (req_snap[b] && !we_snap[b]) ? mem_word(b, addr_snap[b]) : Garbage;
        end
        #1;
        exp_rv = '0;
        while (sbq4.size() > 0) begin
            r = sbq4.pop_front();
            exp_rv[r.port] = 1'b1;
            check({tag, " rdata4"}, rdata4[r.port], r.data);
        end
        check({tag, " rvalid4"}, 64'(rvalid4), 64'(exp_rv));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        req    = 2'b11;
        we     = '0;
        addr   = '0;
        wdata  = '0;
        strb   = '0;
        brdata = '0;
        req4   = '0;
        we4    = '0;
        addr4  = '0;
        wdata4 = '0;
        strb4  = '0;
        brdata4 = '0;

        // Reset state: requests present but everything forced low.
        @(negedge clk);
        #1;
        check("rst gnt", 64'(gnt), 64'h0);
        check("rst bank_req", 64'(breq), 64'h0);
        check("rst rvalid", 64'(rvalid), 64'h0);
        check("rst rdata", 64'(rdata), 64'h0);
        check("rst gnt4", 64'(gnt4), 64'h0);
        @(posedge clk);
        #1;
        check("rst rvalid after edge", 64'(rvalid), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Two ports, two different banks, same cycle.
        req = 2'b11; we = 2'b00;
        addr[0] = 18'h08; addr[1] = 18'h10;
        step(2'b11, 4'b0110, "dual");

        // Contention on bank 0: alternating grants.
        addr[0] = 18'h00; addr[1] = 18'h00;
        step(2'b01, 4'b0001, "rr c0");
        step(2'b10, 4'b0001, "rr c1");
        step(2'b01, 4'b0001, "rr c2");
        step(2'b10, 4'b0001, "rr c3");

        // Idle cycle with junk payload: must be ignored.
        req = 2'b00; we = 2'b11;
        addr[0] = 18'h3FFFF; addr[1] = 18'h12345;
        step(2'b00, 4'b0000, "idle");

        // Write on port 0; port 1 holds junk with no request.
        req = 2'b01; we = 2'b11;
        addr[0] = 18'h20; wdata[0] = 64'hDEADBEEF; strb[0] = 8'hFF;
        addr[1] = 18'h20; wdata[1] = 64'h1111; strb[1] = 8'h0F;
        #1;
        check("wr bank_we", 64'(bwe), 64'h1);
        check("wr bank_addr", 64'(baddr), 64'h1);
        check("wr bank_wdata", bwdata[0], 64'hDEADBEEF);
        check("wr bank_be", 64'(bbe), 64'hFF);
        step(2'b01, 4'b0001, "wr");

        // Write and read on different banks, then back-to-back reads.
        req = 2'b11; we = 2'b01;
        addr[0] = 18'h08; addr[1] = 18'h18;
        step(2'b11, 4'b1010, "mix");
        we = 2'b00;
        addr[0] = 18'h28; addr[1] = 18'h38;
        step(2'b11, 4'b1010, "b2b0");
        addr[0] = 18'h30;
        step(2'b11, 4'b1100, "b2b1");

        // Move bank 0 pointer to port 1, then reset with a grant in flight.
        req = 2'b01; addr[0] = 18'h00;
        step(2'b01, 4'b0001, "pre rst");
        req = 2'b10; addr[1] = 18'h00;
        #1;
        check("inflight gnt", 64'(gnt), 64'h2);
        rst = 1'b1;
        #1;
        check("inflight gnt in rst", 64'(gnt), 64'h0);
        check("inflight bank_req in rst", 64'(breq), 64'h0);
        @(posedge clk);
        #1;
        check("inflight rvalid", 64'(rvalid), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Pending response cleared asynchronously by reset.
        req = 2'b01; addr[0] = 18'h08;
        #1;
        check("pend gnt", 64'(gnt), 64'h1);
        @(posedge clk);
        #1;
        check("pend rvalid", 64'(rvalid), 64'h1);
        rst = 1'b1;
        #1;
        check("pend rvalid cleared", 64'(rvalid), 64'h0);
        check("pend rdata cleared", 64'(rdata), 64'h0);
        req = 2'b00;
        @(negedge clk);
        rst = 1'b0;

        // After reset the pointer is back at port 0.
        req = 2'b11; addr[0] = 18'h00; addr[1] = 18'h00;
        step(2'b01, 4'b0001, "post rst p0");
        step(2'b10, 4'b0001, "post rst p1");
        req = 2'b00;

        // Four ports hammering bank 3, each with its own word.
        req4 = 4'hF; we4 = 4'h0;
        for (int p = 0; p < 4; p++) begin
            addr4[p] = 18'h18 + 18'(p * 32);
        end
        for (int i = 0; i < 8; i++) begin
            step4(4'(1 << (i % 4)), 4'b1000, "hammer");
        end
        req4 = 4'h0;
        step4(4'h0, 4'h0, "hammer idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
